// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg -- shared types and default sizes for mem_port_arbiter | rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   localparam int DEF_ADDR_W      = 16;
   localparam int DEF_DATA_W      = 16;
   localparam int DEF_D_BURST_MAX = 4;
   localparam int DEF_CNT_W       = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_arb_select.sv
// ============================================================================
// arb_select -- data-priority winner choice with fetch starvation bound | rev 1.0
// ============================================================================
`default_nettype none

module arb_select
   import mem_arb_pkg::*;
#(
   parameter int D_BURST_MAX = DEF_D_BURST_MAX,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_req,
   input  logic   d_req,
   input  logic   arb,
   output owner_t winner
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(D_BURST_MAX);

   logic [CNT_W-1:0] count;
   logic             fetch_due;

   assign fetch_due = i_req && (count == CNT_MAX);

   always_comb begin
      winner = OWN_NONE;
      if (d_req && !fetch_due) begin
         winner = OWN_D;
      end else if (i_req) begin
         winner = OWN_I;
      end
   end

   // Counts data grants that overtook a waiting fetch; any fetch grant or idle fetch side clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (arb) begin
         if (!i_req || (winner == OWN_I)) begin
            count <= '0;
         end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter -- shares one memory port between fetch and data misses | rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int D_BURST_MAX = DEF_D_BURST_MAX,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_busy,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err
);

   state_t state, next_state;
   owner_t owner, winner;
   logic   arb;
   logic   owner_req;
   logic   proto_err;

   assign arb = (state == IDLE) && (i_req || d_req);

   arb_select #(
      .D_BURST_MAX (D_BURST_MAX),
      .CNT_W       (CNT_W)
   ) u_sel (
      .clk    (clk),
      .rst    (rst),
      .i_req  (i_req),
      .d_req  (d_req),
      .arb    (arb),
      .winner (winner)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (i_req || d_req) next_state = ISSUE;
         ISSUE:   if (!mem_busy)      next_state = WAIT;
         WAIT:    if (mem_done)       next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign owner_req = (owner == OWN_I) ? i_req :
                      (owner == OWN_D) ? d_req : 1'b1;

   // A fetch reading the very word a simultaneous store targets is flagged but still arbitrated.
   assign proto_err = (mem_done && (state != WAIT))
                   || (((state == ISSUE) || (state == WAIT)) && !owner_req)
                   || (i_req && d_req && d_wr && (i_addr == d_addr));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner     <= OWN_NONE;
         i_gnt     <= 1'b0;
         i_done    <= 1'b0;
         i_rdata   <= '0;
         d_gnt     <= 1'b0;
         d_done    <= 1'b0;
         d_rdata   <= '0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
      end else begin
         if (proto_err) begin
            err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (arb) begin
                  owner  <= winner;
                  mem_en <= 1'b1;
                  if (winner == OWN_D) begin
                     d_gnt     <= 1'b1;
                     mem_wr    <= d_wr;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     i_gnt     <= 1'b1;
                     mem_wr    <= 1'b0;
                     mem_addr  <= i_addr;
                     mem_wdata <= '0;
                  end
               end
            end
            ISSUE: begin
               if (!mem_busy) begin
                  mem_en <= 1'b0;
               end
            end
            WAIT: begin
               if (mem_done) begin
                  if (owner == OWN_I) begin
                     i_done  <= 1'b1;
                     i_rdata <= mem_rdata;
                  end else begin
                     d_done <= 1'b1;
                     if (!mem_wr) begin
                        d_rdata <= mem_rdata;
                     end
                  end
               end
            end
            DONE: begin
               owner  <= OWN_NONE;
               i_gnt  <= 1'b0;
               i_done <= 1'b0;
               d_gnt  <= 1'b0;
               d_done <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
